// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: fetch port, data port, shared memory port and status.
// The arbiter connects through modport slave; the environment drives through master.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) ();
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ready;

    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ready;

    logic              m_en;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;
    logic              m_ack;

    logic              busy;
    logic              err;

    modport slave (
        input  i_req, i_addr, d_read, d_write, d_addr, d_wdata, m_rdata, m_ack,
        output i_rdata, i_ready, d_rdata, d_ready, m_en, m_we, m_addr, m_wdata, busy, err
    );

    modport master (
        output i_req, i_addr, d_read, d_write, d_addr, d_wdata, m_rdata, m_ack,
        input  i_rdata, i_ready, d_rdata, d_ready, m_en, m_we, m_addr, m_wdata, busy, err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) arbiter onto one memory port, data-first with a fetch anti-starvation streak.
// Optional access watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned MAX_D_STREAK = 4,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic          CLK,
    input  logic          RESET,
    mem_arbiter_if.slave  bus
);
    localparam int unsigned STREAK_W = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);

    typedef enum logic [1:0] {IDLE, I_ACC, D_ACC} state_e;

    state_e              state_q, state_d;
    logic [STREAK_W-1:0] d_streak_q, d_streak_d;
    logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
    logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
    logic                m_we_q, m_we_d;
    logic                active_q, active_d;
    logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                i_ready_q, i_ready_d;
    logic                d_ready_q, d_ready_d;

    logic                arb_open, d_pend, grant_i, grant_d;
    logic                acc_end, acc_tout;
    logic [DATA_W-1:0]   rd_val;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned TMR_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             err_q, err_d;
`endif

    // A completing requester's still-held request must not re-issue, so no grant is made while any ready pulses.
    always_comb begin
        arb_open = !i_ready_q && !d_ready_q;
        d_pend   = bus.d_read || bus.d_write;
        grant_i  = arb_open && bus.i_req &&
                   (!d_pend || (d_streak_q == STREAK_W'(MAX_D_STREAK)));
        grant_d  = arb_open && d_pend && !grant_i;
    end

    // Next-state, latched memory command and completion outputs.
    always_comb begin
        state_d    = state_q;
        d_streak_d = d_streak_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        m_we_d     = m_we_q;
        i_rdata_d  = i_rdata_q;
        d_rdata_d  = d_rdata_q;
        i_ready_d  = 1'b0;
        d_ready_d  = 1'b0;
        acc_end    = 1'b0;
        acc_tout   = 1'b0;
        rd_val     = bus.m_rdata;
`ifdef MEM_ARB_TIMEOUT_EN
        timer_d    = timer_q;
        err_d      = 1'b0;
`endif

        case (state_q)
            IDLE: begin
`ifdef MEM_ARB_TIMEOUT_EN
                timer_d = '0;
`endif
                if (grant_i) begin
                    state_d    = I_ACC;
                    m_addr_d   = bus.i_addr;
                    m_wdata_d  = '0;
                    m_we_d     = 1'b0;
                    d_streak_d = '0;
                end else if (grant_d) begin
                    state_d   = D_ACC;
                    m_addr_d  = bus.d_addr;
                    m_wdata_d = bus.d_wdata;
                    m_we_d    = bus.d_write;
                    if (!bus.i_req) begin
                        d_streak_d = '0;
                    end else if (d_streak_q != STREAK_W'(MAX_D_STREAK)) begin
                        d_streak_d = d_streak_q + STREAK_W'(1);
                    end
                end
            end
            I_ACC, D_ACC: begin
                if (bus.m_ack) begin
                    acc_end = 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    acc_end  = 1'b1;
                    acc_tout = 1'b1;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        // A timed-out read returns zero in place of memory data.
        if (acc_end) begin
            state_d = IDLE;
            if (acc_tout) begin
                rd_val = '0;
            end
`ifdef MEM_ARB_TIMEOUT_EN
            err_d = acc_tout;
`endif
            if (state_q == I_ACC) begin
                i_ready_d = 1'b1;
                i_rdata_d = rd_val;
            end else begin
                d_ready_d = 1'b1;
                if (!m_we_q) begin
                    d_rdata_d = rd_val;
                end
            end
        end

        active_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= IDLE;
            d_streak_q <= '0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            m_we_q     <= 1'b0;
            active_q   <= 1'b0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
            i_ready_q  <= 1'b0;
            d_ready_q  <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            timer_q    <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            d_streak_q <= d_streak_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            m_we_q     <= m_we_d;
            active_q   <= active_d;
            i_rdata_q  <= i_rdata_d;
            d_rdata_q  <= d_rdata_d;
            i_ready_q  <= i_ready_d;
            d_ready_q  <= d_ready_d;
`ifdef MEM_ARB_TIMEOUT_EN
            timer_q    <= timer_d;
            err_q      <= err_d;
`endif
        end
    end

    assign bus.m_en    = active_q;
    assign bus.busy    = active_q;
    assign bus.m_we    = m_we_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_wdata = m_wdata_q;
    assign bus.i_rdata = i_rdata_q;
    assign bus.d_rdata = d_rdata_q;
    assign bus.i_ready = i_ready_q;
    assign bus.d_ready = d_ready_q;
`ifdef MEM_ARB_TIMEOUT_EN
    assign bus.err     = err_q;
`else
    assign bus.err     = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table plus sequences for
// streak arbitration, watchdog timeout (when MEM_ARB_TIMEOUT_EN is defined) and mid-access reset.
module tb_mem_arbiter;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam logic [31:0] IR1 = 32'h0050_0093;
    localparam logic [31:0] DR1 = 32'hCAFE_F00D;
    localparam logic [31:0] DR2 = 32'h0BAD_F00D;
    localparam int NVEC = 20;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MAX_D_STREAK(4), .TIMEOUT(8)
    ) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic        ireq;
        logic [31:0] iaddr;
        logic        dr;
        logic        dw;
        logic [31:0] daddr;
        logic [31:0] dwd;
        logic        ack;
        logic [31:0] mrd;
        logic        e_en;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wd;
        logic        e_ir;
        logic        e_dr;
        logic [31:0] e_ird;
        logic [31:0] e_drd;
        logic        e_busy;
    } vec_t;

    vec_t vecs [NVEC];

    function automatic vec_t mk(
        input logic rst_v, input logic ireq, input logic [31:0] iaddr,
        input logic dr, input logic dw, input logic [31:0] daddr, input logic [31:0] dwd,
        input logic ack, input logic [31:0] mrd,
        input logic e_en, input logic e_we, input logic [31:0] e_addr, input logic [31:0] e_wd,
        input logic e_ir, input logic e_dr, input logic [31:0] e_ird, input logic [31:0] e_drd,
        input logic e_busy);
        vec_t v;
        v.rst = rst_v;  v.ireq = ireq;  v.iaddr = iaddr;
        v.dr = dr;  v.dw = dw;  v.daddr = daddr;  v.dwd = dwd;
        v.ack = ack;  v.mrd = mrd;
        v.e_en = e_en;  v.e_we = e_we;  v.e_addr = e_addr;  v.e_wd = e_wd;
        v.e_ir = e_ir;  v.e_dr = e_dr;  v.e_ird = e_ird;  v.e_drd = e_drd;
        v.e_busy = e_busy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        rst = 1'b0;
        bus.i_req = 1'b0;  bus.i_addr = '0;
        bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.m_ack = 1'b0;  bus.m_rdata = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic exp_i [7];
        logic got_i;
        int   waited;
        int   ncyc;

        n_chk  = 0;
        n_fail = 0;
        drive_idle();

        //            rst ireq iaddr  dr dw daddr  dwd            ack mrd            en we addr    wd             ir dr ird            drd  busy
        vecs[0]  = mk(1, 0, 32'h0,  0, 0, 32'h0,   32'h0,         0, 32'h0,         0, 0, 32'h0,   32'h0,         0, 0, 32'h0,         32'h0, 0);
        vecs[1]  = mk(0, 1, 32'h40, 0, 0, 32'h0,   32'h0,         0, 32'h0,         1, 0, 32'h40,  32'h0,         0, 0, 32'h0,         32'h0, 1);
        vecs[2]  = mk(0, 1, 32'h40, 0, 0, 32'h0,   32'h0,         1, IR1,           0, 0, 32'h40,  32'h0,         1, 0, IR1,           32'h0, 0);
        vecs[3]  = mk(0, 0, 32'h0,  0, 0, 32'h0,   32'h0,         0, 32'h0,         0, 0, 32'h40,  32'h0,         0, 0, IR1,           32'h0, 0);
        vecs[4]  = mk(0, 0, 32'h0,  1, 0, 32'h104, 32'h0,         0, 32'h0,         1, 0, 32'h104, 32'h0,         0, 0, IR1,           32'h0, 1);
        vecs[5]  = mk(0, 0, 32'h0,  1, 0, 32'h104, 32'h0,         1, DR1,           0, 0, 32'h104, 32'h0,         0, 1, IR1,           DR1,   0);
        vecs[6]  = mk(0, 0, 32'h0,  1, 0, 32'h104, 32'h0,         0, 32'h0,         0, 0, 32'h104, 32'h0,         0, 0, IR1,           DR1,   0);
        vecs[7]  = mk(0, 0, 32'h0,  0, 1, 32'h100, 32'hDEADBEEF,  0, 32'h0,         1, 1, 32'h100, 32'hDEADBEEF,  0, 0, IR1,           DR1,   1);
        vecs[8]  = mk(0, 0, 32'h0,  0, 1, 32'h200, 32'h11111111,  0, 32'h0,         1, 1, 32'h100, 32'hDEADBEEF,  0, 0, IR1,           DR1,   1);
        vecs[9]  = mk(0, 0, 32'h0,  0, 1, 32'h100, 32'hDEADBEEF,  1, 32'h12345678,  0, 1, 32'h100, 32'hDEADBEEF,  0, 1, IR1,           DR1,   0);
        vecs[10] = mk(0, 0, 32'h0,  0, 0, 32'h0,   32'h0,         1, 32'hAAAAAAAA,  0, 1, 32'h100, 32'hDEADBEEF,  0, 0, IR1,           DR1,   0);
        vecs[11] = mk(0, 0, 32'h0,  1, 1, 32'h300, 32'h55AA55AA,  0, 32'h0,         1, 1, 32'h300, 32'h55AA55AA,  0, 0, IR1,           DR1,   1);
        vecs[12] = mk(0, 0, 32'h0,  1, 1, 32'h300, 32'h55AA55AA,  1, 32'h99999999,  0, 1, 32'h300, 32'h55AA55AA,  0, 1, IR1,           DR1,   0);
        vecs[13] = mk(0, 0, 32'h0,  0, 0, 32'h0,   32'h0,         0, 32'h0,         0, 1, 32'h300, 32'h55AA55AA,  0, 0, IR1,           DR1,   0);
        vecs[14] = mk(0, 1, 32'h80, 1, 0, 32'h108, 32'h0,         0, 32'h0,         1, 0, 32'h108, 32'h0,         0, 0, IR1,           DR1,   1);
        vecs[15] = mk(0, 1, 32'h80, 1, 0, 32'h108, 32'h0,         1, DR2,           0, 0, 32'h108, 32'h0,         0, 1, IR1,           DR2,   0);
        vecs[16] = mk(0, 1, 32'h80, 0, 0, 32'h0,   32'h0,         0, 32'h0,         0, 0, 32'h108, 32'h0,         0, 0, IR1,           DR2,   0);
        vecs[17] = mk(0, 1, 32'h80, 0, 0, 32'h0,   32'h0,         0, 32'h0,         1, 0, 32'h80,  32'h0,         0, 0, IR1,           DR2,   1);
        vecs[18] = mk(0, 1, 32'h80, 0, 0, 32'h0,   32'h0,         1, 32'h00112233,  0, 0, 32'h80,  32'h0,         1, 0, 32'h00112233,  DR2,   0);
        vecs[19] = mk(0, 0, 32'h0,  0, 0, 32'h0,   32'h0,         0, 32'h0,         0, 0, 32'h80,  32'h0,         0, 0, 32'h00112233,  DR2,   0);

        // One vector per clock: drive, clock, then compare every output.
        for (int i = 0; i < NVEC; i++) begin
            rst         = vecs[i].rst;
            bus.i_req   = vecs[i].ireq;
            bus.i_addr  = vecs[i].iaddr;
            bus.d_read  = vecs[i].dr;
            bus.d_write = vecs[i].dw;
            bus.d_addr  = vecs[i].daddr;
            bus.d_wdata = vecs[i].dwd;
            bus.m_ack   = vecs[i].ack;
            bus.m_rdata = vecs[i].mrd;
            step();
            chk($sformatf("v%0d.m_en", i),    32'(bus.m_en),    32'(vecs[i].e_en));
            chk($sformatf("v%0d.m_we", i),    32'(bus.m_we),    32'(vecs[i].e_we));
            chk($sformatf("v%0d.m_addr", i),  bus.m_addr,       vecs[i].e_addr);
            chk($sformatf("v%0d.m_wdata", i), bus.m_wdata,      vecs[i].e_wd);
            chk($sformatf("v%0d.i_ready", i), 32'(bus.i_ready), 32'(vecs[i].e_ir));
            chk($sformatf("v%0d.d_ready", i), 32'(bus.d_ready), 32'(vecs[i].e_dr));
            chk($sformatf("v%0d.i_rdata", i), bus.i_rdata,      vecs[i].e_ird);
            chk($sformatf("v%0d.d_rdata", i), bus.d_rdata,      vecs[i].e_drd);
            chk($sformatf("v%0d.busy", i),    32'(bus.busy),    32'(vecs[i].e_busy));
            chk($sformatf("v%0d.err", i),     32'(bus.err),     32'(1'b0));
        end

        // Fetch held against back-to-back data reads: expected grant order D,D,D,D,I,D,D.
        exp_i = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        drive_idle();
        bus.i_req  = 1'b1;  bus.i_addr = 32'h400;
        bus.d_read = 1'b1;  bus.d_addr = 32'h500;
        for (int g = 0; g < 7; g++) begin
            waited = 0;
            while (!bus.m_en && waited < 10) begin
                step();
                waited++;
            end
            chk($sformatf("streak.grant%0d_seen", g), 32'(bus.m_en), 32'(1'b1));
            got_i = (bus.m_addr == 32'h400);
            chk($sformatf("streak.grant%0d_is_fetch", g), 32'(got_i), 32'(exp_i[g]));
            bus.m_rdata = 32'h5A5A_0000 + 32'(g);
            bus.m_ack   = 1'b1;
            step();
            bus.m_ack   = 1'b0;
        end
        bus.i_req  = 1'b0;
        bus.d_read = 1'b0;
        step();
        chk("streak.busy_after", 32'(bus.busy), 32'(1'b0));
        chk("streak.d_rdata_last", bus.d_rdata, 32'h5A5A_0006);
        chk("streak.i_rdata_fetch", bus.i_rdata, 32'h5A5A_0004);

`ifdef MEM_ARB_TIMEOUT_EN
        // Read with no ack: ready and err pulse after 8 access cycles, rdata forced to 0.
        bus.d_read = 1'b1;  bus.d_addr = 32'h700;
        step();
        chk("tout.m_en", 32'(bus.m_en), 32'(1'b1));
        ncyc = 0;
        while (!bus.d_ready && ncyc < 20) begin
            step();
            ncyc++;
        end
        bus.d_read = 1'b0;
        chk("tout.cycles", 32'(ncyc), 32'd8);
        chk("tout.err", 32'(bus.err), 32'(1'b1));
        chk("tout.d_rdata", bus.d_rdata, 32'h0);
        step();
        chk("tout.err_cleared", 32'(bus.err), 32'(1'b0));

        // Ack on the expiry cycle completes normally without err.
        bus.d_read = 1'b1;  bus.d_addr = 32'h704;
        step();
        repeat (7) @(posedge clk);
        #1;
        bus.m_ack   = 1'b1;
        bus.m_rdata = 32'h0000_0077;
        step();
        bus.m_ack  = 1'b0;
        bus.d_read = 1'b0;
        chk("tout_ack.d_ready", 32'(bus.d_ready), 32'(1'b1));
        chk("tout_ack.err", 32'(bus.err), 32'(1'b0));
        chk("tout_ack.d_rdata", bus.d_rdata, 32'h0000_0077);
        step();
`endif

        // Reset mid data access, then a stale ack: everything stays cleared.
        drive_idle();
        bus.d_read = 1'b1;  bus.d_addr = 32'h600;
        step();
        chk("rst.m_en_before", 32'(bus.m_en), 32'(1'b1));
        rst        = 1'b1;
        bus.d_read = 1'b0;
        step();
        chk("rst.m_en",    32'(bus.m_en),    32'(1'b0));
        chk("rst.m_we",    32'(bus.m_we),    32'(1'b0));
        chk("rst.m_addr",  bus.m_addr,       32'h0);
        chk("rst.m_wdata", bus.m_wdata,      32'h0);
        chk("rst.i_rdata", bus.i_rdata,      32'h0);
        chk("rst.d_rdata", bus.d_rdata,      32'h0);
        chk("rst.i_ready", 32'(bus.i_ready), 32'(1'b0));
        chk("rst.d_ready", 32'(bus.d_ready), 32'(1'b0));
        chk("rst.busy",    32'(bus.busy),    32'(1'b0));
        chk("rst.err",     32'(bus.err),     32'(1'b0));
        rst         = 1'b0;
        bus.m_ack   = 1'b1;
        bus.m_rdata = 32'h0000_FFFF;
        step();
        bus.m_ack = 1'b0;
        chk("rst_ack.d_ready", 32'(bus.d_ready), 32'(1'b0));
        chk("rst_ack.busy",    32'(bus.busy),    32'(1'b0));
        chk("rst_ack.d_rdata", bus.d_rdata,      32'h0);
        step();
        chk("rst_ack.d_ready_later", 32'(bus.d_ready), 32'(1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 32, address width; DATA_W, default 32, data width; MAX_D_STREAK, default 4, maximum consecutive data grants while a fetch waits; TIMEOUT, default 255, watchdog limit in cycles.
REQ-002 CLK  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 RESET  in  1  synchronous, active-high reset.
REQ-004 i_req  in  1  fetch request; i_addr  in  ADDR_W  fetch address.
REQ-005 i_rdata  out  DATA_W  fetched word; i_ready  out  1  one-cycle fetch completion pulse.
REQ-006 d_read  in  1, d_write  in  1  data-stage read and write requests.
REQ-007 d_addr  in  ADDR_W, d_wdata  in  DATA_W  data-stage address and store data.
REQ-008 d_rdata  out  DATA_W  loaded word; d_ready  out  1  one-cycle data completion pulse.
REQ-009 m_en  out  1, m_we  out  1, m_addr  out  ADDR_W, m_wdata  out  DATA_W  shared memory port.
REQ-010 m_rdata  in  DATA_W, m_ack  in  1  memory read data and access-complete strobe.
REQ-011 busy  out  1  high whenever state is not IDLE; err  out  1  one-cycle timeout pulse.

Function
REQ-012 FSM states SHALL be IDLE, I_ACC and D_ACC; busy = (state != IDLE).
REQ-013 In IDLE, a pending request SHALL cause a transition at the next edge to I_ACC or D_ACC.
REQ-014 On that transition, address, write data and we SHALL be latched into m_addr, m_wdata and m_we; m_en SHALL be 1 exactly while in I_ACC or D_ACC.
REQ-015 Arbitration SHALL give data priority over fetch when both requests are pending.
REQ-016 Exception to REQ-015: when d_streak equals MAX_D_STREAK, the fetch SHALL be granted.
REQ-017 d_streak SHALL increment on each data grant made while i_req is high.
REQ-018 d_streak SHALL clear on a fetch grant, and on any data grant made while i_req is low.
REQ-019 d_streak SHALL saturate at MAX_D_STREAK.
REQ-020 If d_read and d_write are both high, the access SHALL be treated as a write (m_we=1).
REQ-021 In an ACC state with m_ack=1 at an edge, the FSM SHALL return to IDLE.
REQ-022 At that same edge, the matching ready SHALL pulse high for the following cycle only.
REQ-023 For reads, m_rdata SHALL be captured into i_rdata or d_rdata at the ack edge.
REQ-024 For writes, d_rdata SHALL hold its previous value.
REQ-025 Minimum latency SHALL be 2 cycles: request at cycle 0, m_en at cycle 1, ack at cycle 1, ready at cycle 2.
REQ-026 Requesters SHALL hold request and operands stable until their ready pulse.
REQ-027 In the cycle a requester's ready is high, that requester's request SHALL be ignored by arbitration, so no duplicate access occurs.
REQ-028 Request changes during ACC states SHALL NOT affect m_addr, m_wdata or m_we.
REQ-029 m_ack while in IDLE SHALL be ignored.
REQ-030 i_rdata and d_rdata SHALL hold their values between completions.

Reset
REQ-031 RESET high at an edge SHALL force state=IDLE and d_streak=0, including mid-access.
REQ-032 RESET high at an edge SHALL force all outputs to 0 (m_en, m_we, m_addr, m_wdata, i_rdata, d_rdata, i_ready, d_ready, busy, err).
REQ-033 An access aborted by reset SHALL produce no ready pulse.
REQ-034 An m_ack arriving after a reset-aborted access SHALL be ignored.

Configuration
REQ-035 With MEM_ARB_TIMEOUT_EN defined, a counter SHALL clear on ACC entry and count each ACC cycle without m_ack.
REQ-036 With MEM_ARB_TIMEOUT_EN defined, on reaching TIMEOUT the FSM SHALL return to IDLE.
REQ-037 On that timeout, the matching ready SHALL pulse, its rdata SHALL load 0 for reads, and err SHALL pulse for one cycle.
REQ-038 With MEM_ARB_TIMEOUT_EN defined, m_ack on the expiry cycle SHALL win, with no err pulse.
REQ-039 Without MEM_ARB_TIMEOUT_EN, the arbiter SHALL wait indefinitely for m_ack, err SHALL be tied to 0, and no counter logic SHALL be present.

Verification
REQ-040 Single fetch, i_addr=0x40, m_ack one cycle after m_en, m_rdata=0x00500093 -> i_ready pulses at cycle 2 and i_rdata=0x00500093.
REQ-041 i_req and d_read both high at cycle 0 -> data access first; fetch m_en follows once d_ready has pulsed.
REQ-042 i_req held high with 6 back-to-back data requests, MAX_D_STREAK=4 -> grant order D,D,D,D,I,D,D.
REQ-043 d_write with d_addr=0x100, d_wdata=0xDEADBEEF -> m_we=1, m_addr=0x100 and m_wdata=0xDEADBEEF while m_en; d_ready pulses and d_rdata is unchanged.
REQ-044 RESET asserted for 1 cycle mid D_ACC, then m_ack arrives -> IDLE, all outputs 0, no d_ready pulse.
REQ-045 MEM_ARB_TIMEOUT_EN defined, TIMEOUT=8, m_ack never asserted on a read -> after 8 ACC cycles d_ready and err pulse together and d_rdata=0.
